// File: rtl/asmd_seq_counter_pkg.sv
// Types shared by the ASMD sequence counter: FSM state codes and the
// controller-to-datapath strobe bundle.
package asmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic clr_A_F;
        logic incr_A;
        logic set_E;
        logic clr_E;
        logic set_F;
    } strobe_t;

endpackage

// File: rtl/asmd_seq_counter_if.sv
// Handshake and status bundle of the ASMD sequence counter; the sequencing
// level drives the requests (master), the counter answers (slave).
interface asmd_seq_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic             auto_restart;
    logic [WIDTH-1:0] A;
    logic             E;
    logic             F;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, abort, auto_restart,
        input  A, E, F, busy, done, aborted
    );

    modport slave (
        input  start, abort, auto_restart,
        output A, E, F, busy, done, aborted
    );
endinterface

// File: rtl/asmd_seq_ctrl.sv
// ASMD controller: state register, next-state logic, datapath strobes and
// the Moore busy/done outputs plus the registered aborted pulse.
module asmd_seq_ctrl
    import asmd_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] STOP_MASK = 4'b1100,
    parameter int               E_BIT     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             auto_restart,
    input  logic [WIDTH-1:0] A,
    output strobe_t          strobe,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t state;
    state_t state_next;
    logic   stop_hit;

    // Termination looks at the pre-increment counter value.
    assign stop_hit = (A & STOP_MASK) == STOP_MASK;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            aborted <= 1'b0;
        end else begin
            state   <= state_next;
            aborted <= (state == S_COUNT) && abort;
        end
    end

    // Abort outranks termination; in S_DONE set_F beats clr_A_F in the datapath.
    always_comb begin
        state_next = state;
        strobe     = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    strobe.clr_A_F = 1'b1;
                    state_next     = S_COUNT;
                end
            end
            S_COUNT: begin
                strobe.incr_A = 1'b1;
                strobe.set_E  = A[E_BIT];
                strobe.clr_E  = !A[E_BIT];
                if (abort) begin
                    state_next = S_IDLE;
                end else if (stop_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                strobe.set_F = 1'b1;
                if (auto_restart) begin
                    strobe.clr_A_F = 1'b1;
                    state_next     = S_COUNT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: rtl/asmd_seq_datapath.sv
// ASMD datapath: counter A and flags E, F, changed only through controller strobes.
module asmd_seq_datapath
    import asmd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  strobe_t          strobe,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F
);

    // set_F has priority so F still rises on an auto-restart edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            A <= '0;
            E <= 1'b0;
            F <= 1'b0;
        end else begin
            if (strobe.clr_A_F) begin
                A <= '0;
            end else if (strobe.incr_A) begin
                A <= A + WIDTH'(1);
            end

            if (strobe.set_E) begin
                E <= 1'b1;
            end else if (strobe.clr_E) begin
                E <= 1'b0;
            end

            if (strobe.set_F) begin
                F <= 1'b1;
            end else if (strobe.clr_A_F) begin
                F <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/asmd_seq_counter.sv
// ASMD start/count/flag engine: wires the controller to the datapath and
// exposes both through the handshake interface.
module asmd_seq_counter
    import asmd_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] STOP_MASK = 4'b1100,
    parameter int               E_BIT     = 2
) (
    input logic               clock,
    input logic               reset,
    asmd_seq_counter_if.slave bus
);

    strobe_t strobe;

    asmd_seq_ctrl #(
        .WIDTH     (WIDTH),
        .STOP_MASK (STOP_MASK),
        .E_BIT     (E_BIT)
    ) u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .start        (bus.start),
        .abort        (bus.abort),
        .auto_restart (bus.auto_restart),
        .A            (bus.A),
        .strobe       (strobe),
        .busy         (bus.busy),
        .done         (bus.done),
        .aborted      (bus.aborted)
    );

    asmd_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .strobe (strobe),
        .A      (bus.A),
        .E      (bus.E),
        .F      (bus.F)
    );

endmodule

// File: tb/tb_asmd_seq_counter.sv
// Self-checking bench for asmd_seq_counter: directed scenarios plus randomized
// runs, checked against a run-level model computed from the counting rules.
module tb_asmd_seq_counter;

    localparam int         W0  = 4;
    localparam logic [3:0] M0  = 4'b1100;
    localparam int         EB0 = 2;
    localparam int         W1  = 3;
    localparam logic [2:0] M1  = 3'b000;
    localparam int         EB1 = 1;

    logic clock = 1'b0;
    logic reset;
    int   nVectors     = 0;
    int   nMiscompares = 0;

    int   mA0 = 0;
    int   mE0 = 0;
    int   mF0 = 0;

    asmd_seq_counter_if #(.WIDTH(W0)) bus0 ();
    asmd_seq_counter_if #(.WIDTH(W1)) bus1 ();

    asmd_seq_counter #(.WIDTH(W0), .STOP_MASK(M0), .E_BIT(EB0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    asmd_seq_counter #(.WIDTH(W1), .STOP_MASK(M1), .E_BIT(EB1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Index of the first counter value whose masked bits are all ones.
    function automatic int firstMatch(input int mask, input int width);
        for (int a = 0; a < (1 << width); a++) begin
            if ((a & mask) == mask) return a;
        end
        return -1;
    endfunction

    function automatic int bitOf(input int value, input int idx);
        return (value >> idx) & 1;
    endfunction

    // One start-initiated run on dut0; abortAt is the COUNT cycle index to abort on
    // (beyond the run length means no abort). Random start noise must be ignored.
    task automatic applyStimulus(input int abortAt);
        int k;
        k = firstMatch(int'(M0), W0);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int cyc = 0; cyc <= k; cyc++) begin
            checkOutput("count_A", bus0.A, cyc);
            checkOutput("count_busy", bus0.busy, 1);
            checkOutput("count_done", bus0.done, 0);
            checkOutput("count_E", bus0.E, mE0);
            checkOutput("count_aborted", bus0.aborted, 0);
            bus0.start = 1'($urandom_range(0, 1));
            if (cyc == abortAt) bus0.abort = 1'b1;
            tick();
            bus0.start = 1'b0;
            bus0.abort = 1'b0;
            mE0 = bitOf(cyc, EB0);
            if (cyc == abortAt) begin
                mA0 = (cyc + 1) % (1 << W0);
                mF0 = 0;
                checkOutput("abort_pulse", bus0.aborted, 1);
                checkOutput("abort_busy", bus0.busy, 0);
                checkOutput("abort_A", bus0.A, mA0);
                checkOutput("abort_E", bus0.E, mE0);
                checkOutput("abort_F", bus0.F, 0);
                checkOutput("abort_done", bus0.done, 0);
                tick();
                checkOutput("abort_pulse_end", bus0.aborted, 0);
                checkOutput("abort_idle_A", bus0.A, mA0);
                return;
            end
        end
        mA0 = (k + 1) % (1 << W0);
        checkOutput("done_pulse", bus0.done, 1);
        checkOutput("done_busy", bus0.busy, 1);
        checkOutput("done_A", bus0.A, mA0);
        checkOutput("done_E", bus0.E, mE0);
        checkOutput("done_F_pending", bus0.F, 0);
        bus0.abort = 1'($urandom_range(0, 1));
        tick();
        bus0.abort = 1'b0;
        mF0 = 1;
        checkOutput("after_done", bus0.done, 0);
        checkOutput("after_busy", bus0.busy, 0);
        checkOutput("after_F", bus0.F, mF0);
        checkOutput("after_A", bus0.A, mA0);
        checkOutput("after_aborted", bus0.aborted, 0);
    endtask

    // Idle cycles with stray abort pulses, which must not disturb anything.
    task automatic idleGap(input int cycles);
        for (int g = 0; g < cycles; g++) begin
            bus0.abort = 1'($urandom_range(0, 1));
            tick();
            bus0.abort = 1'b0;
            checkOutput("idle_busy", bus0.busy, 0);
            checkOutput("idle_aborted", bus0.aborted, 0);
            checkOutput("idle_A", bus0.A, mA0);
            checkOutput("idle_F", bus0.F, mF0);
        end
    endtask

    task automatic autoRestartRuns(input int nRuns);
        int k;
        int cycle;
        int prevDone;
        k        = firstMatch(int'(M0), W0);
        cycle    = 0;
        prevDone = -1;
        bus0.auto_restart = 1'b1;
        bus0.start        = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int run = 0; run < nRuns; run++) begin
            for (int cyc = 0; cyc <= k; cyc++) begin
                checkOutput("ar_A", bus0.A, cyc);
                checkOutput("ar_busy", bus0.busy, 1);
                checkOutput("ar_done_low", bus0.done, 0);
                tick();
                cycle++;
            end
            checkOutput("ar_done", bus0.done, 1);
            if (prevDone >= 0) checkOutput("ar_period", cycle - prevDone, k + 2);
            prevDone = cycle;
            if (run == nRuns - 1) bus0.auto_restart = 1'b0;
            tick();
            cycle++;
            checkOutput("ar_F", bus0.F, 1);
            if (run == nRuns - 1) begin
                checkOutput("ar_final_busy", bus0.busy, 0);
                checkOutput("ar_final_A", bus0.A, k + 1);
            end else begin
                checkOutput("ar_restart_A", bus0.A, 0);
                checkOutput("ar_restart_busy", bus0.busy, 1);
            end
        end
        mA0 = (k + 1) % (1 << W0);
        mE0 = bitOf(k, EB0);
        mF0 = 1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        reset             = 1'b1;
        bus0.start        = 1'b0;
        bus0.abort        = 1'b0;
        bus0.auto_restart = 1'b0;
        bus1.start        = 1'b0;
        bus1.abort        = 1'b0;
        bus1.auto_restart = 1'b0;
        tick();
        tick();
        checkOutput("rst_A", bus0.A, 0);
        checkOutput("rst_E", bus0.E, 0);
        checkOutput("rst_F", bus0.F, 0);
        checkOutput("rst_busy", bus0.busy, 0);
        checkOutput("rst_done", bus0.done, 0);
        checkOutput("rst_aborted", bus0.aborted, 0);
        reset = 1'b0;
        idleGap(2);

        $display("[TB] full run from A=0");
        applyStimulus(99);
        checkOutput("run1_final_E", bus0.E, 1);
        idleGap(1);

        $display("[TB] abort at A=4");
        applyStimulus(4);
        idleGap(1);

        $display("[TB] abort on terminating cycle");
        applyStimulus(firstMatch(int'(M0), W0));
        idleGap(1);

        $display("[TB] auto-restart back-to-back runs");
        autoRestartRuns(3);
        idleGap(1);

        $display("[TB] WIDTH=3 with empty stop mask");
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        checkOutput("w3_A0", bus1.A, 0);
        checkOutput("w3_busy", bus1.busy, 1);
        checkOutput("w3_done_low", bus1.done, 0);
        tick();
        checkOutput("w3_done", bus1.done, 1);
        checkOutput("w3_A1", bus1.A, 1);
        checkOutput("w3_E", bus1.E, bitOf(0, EB1));
        tick();
        checkOutput("w3_idle", bus1.busy, 0);
        checkOutput("w3_F", bus1.F, 1);
        checkOutput("w3_done_end", bus1.done, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            applyStimulus(int'($urandom_range(0, 20)));
            idleGap(int'($urandom_range(0, 3)));
        end

        $display("[TB] reset mid-run at A=7");
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("pre_reset_A", bus0.A, 7);
        bus0.start = 1'b1;
        reset      = 1'b1;
        #1;
        checkOutput("async_A", bus0.A, 0);
        checkOutput("async_E", bus0.E, 0);
        checkOutput("async_F", bus0.F, 0);
        checkOutput("async_busy", bus0.busy, 0);
        checkOutput("async_done", bus0.done, 0);
        checkOutput("async_aborted", bus0.aborted, 0);
        tick();
        tick();
        checkOutput("held_busy", bus0.busy, 0);
        checkOutput("held_done", bus0.done, 0);
        reset      = 1'b0;
        bus0.start = 1'b0;
        mA0 = 0;
        mE0 = 0;
        mF0 = 0;
        idleGap(2);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
